// File: rtl/ship_pkg.sv
// Shared encodings for the player-cannon controller.
// State codes and sprite column width used across the ship logic.
package ship_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    EXPLODING = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int unsigned SPRITE_COL_W = 5;

endpackage

// File: rtl/ship_ctrl_param_tick_divider.sv
// Enable-gated modulo-N counter with synchronous clear.
// zero is high while the count sits at 0.
module tick_divider #(
  parameter int unsigned N = 2,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk_36MHz,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic zero
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk_36MHz) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ship_ctrl_param.sv
// Player-cannon controller: movement with auto-repeat, one-shot fire,
// hit/explosion handling, life counter and game-over.
module ship_ctrl_param
  import ship_pkg::*;
#(
  parameter int unsigned X_W           = SPRITE_COL_W,
  parameter int unsigned X_MAX         = 19,
  parameter int unsigned X_START       = 5,
  parameter int unsigned MOVE_DIV      = 2,
  parameter int unsigned EXPLODE_TICKS = 30,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned LIVES_W       = 2
) (
  input  logic               clk_36MHz,
  input  logic               reset,
  input  logic               enable,
  input  logic               left_debounced,
  input  logic               right_debounced,
  input  logic               fire_debounced,
  input  logic               shot_active,
  input  logic               hit,
  output logic [X_W-1:0]     ship_x,
  output logic               ship_visible,
  output logic               exploding,
  output logic               fire_pulse,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  localparam int unsigned EXP_W = $clog2(EXPLODE_TICKS + 1);

  localparam logic [X_W-1:0]     XMAX_C  = X_W'(X_MAX);
  localparam logic [X_W-1:0]     XSTRT_C = X_W'(X_START);
  localparam logic [LIVES_W-1:0] LIVES_C = LIVES_W'(LIVES);
  localparam logic [EXP_W-1:0]   EXP_C   = EXP_W'(EXPLODE_TICKS);
  localparam logic [EXP_W-1:0]   EXP_ONE = EXP_W'(1);

  if (X_MAX >= (1 << X_W)) begin : g_xmax_chk
    $error("X_MAX does not fit in X_W bits");
  end
  if (X_START > X_MAX) begin : g_xstart_chk
    $error("X_START beyond X_MAX");
  end
  if (LIVES >= (1 << LIVES_W)) begin : g_lives_chk
    $error("LIVES does not fit in LIVES_W bits");
  end
  if (MOVE_DIV < 1 || EXPLODE_TICKS < 1) begin : g_div_chk
    $error("MOVE_DIV and EXPLODE_TICKS must be >= 1");
  end

  state_t           state;
  logic             fire_prev;
  logic [EXP_W-1:0] exp_cnt;
  logic             held;
  logic             moving;
  logic             div_zero;
  logic             div_clear;

  assign held      = left_debounced ^ right_debounced;
  assign moving    = (state == MOVING);
  // Divider only runs while a single direction is held in MOVING.
  assign div_clear = !moving || hit || !held;

  tick_divider #(
    .N (MOVE_DIV)
  ) u_step_div (
    .clk_36MHz (clk_36MHz),
    .reset     (reset),
    .enable    (enable),
    .clear     (div_clear),
    .zero      (div_zero)
  );

  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      state        <= IDLE;
      ship_x       <= XSTRT_C;
      lives        <= LIVES_C;
      ship_visible <= 1'b1;
      exploding    <= 1'b0;
      fire_pulse   <= 1'b0;
      game_over    <= 1'b0;
      exp_cnt      <= '0;
      fire_prev    <= 1'b0;
    end else begin
      fire_prev  <= fire_debounced;
      fire_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) state <= MOVING;
        end
        MOVING: begin
          if (hit) begin
            state        <= EXPLODING;
            ship_visible <= 1'b0;
            exploding    <= 1'b1;
            lives        <= (lives == '0) ? '0 : lives - 1'b1;
            exp_cnt      <= EXP_C;
          end else begin
            fire_pulse <= fire_debounced && !fire_prev
                          && !shot_active;
            if (enable && held && div_zero) begin
              if (left_debounced && ship_x != '0)
                ship_x <= ship_x - 1'b1;
              else if (right_debounced && ship_x != XMAX_C)
                ship_x <= ship_x + 1'b1;
            end
          end
        end
        EXPLODING: begin
          if (enable) begin
            exp_cnt <= exp_cnt - 1'b1;
            if (exp_cnt == EXP_ONE) begin
              exploding <= 1'b0;
              if (lives == '0) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state        <= MOVING;
                ship_visible <= 1'b1;
                ship_x       <= XSTRT_C;
              end
            end
          end
        end
        GAME_OVER: begin
          state <= GAME_OVER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ship_ctrl_param.sv
// Directed bench for ship_ctrl_param: vector table for movement/fire,
// hand sequences for saturation, explosions, game-over and reset.
module tb_ship_ctrl_param;

  logic       clk_36MHz = 1'b0;
  logic       reset, enable, left_debounced, right_debounced;
  logic       fire_debounced, shot_active, hit;
  logic [4:0] ship_x;
  logic       ship_visible, exploding, fire_pulse, game_over;
  logic [1:0] lives;

  int errors = 0;
  int checks = 0;

  always #5 clk_36MHz = ~clk_36MHz;

  ship_ctrl_param dut (
    .clk_36MHz       (clk_36MHz),
    .reset           (reset),
    .enable          (enable),
    .left_debounced  (left_debounced),
    .right_debounced (right_debounced),
    .fire_debounced  (fire_debounced),
    .shot_active     (shot_active),
    .hit             (hit),
    .ship_x          (ship_x),
    .ship_visible    (ship_visible),
    .exploding       (exploding),
    .fire_pulse      (fire_pulse),
    .lives           (lives),
    .game_over       (game_over)
  );

  typedef struct {
    string      nm;
    logic       en, l, r, f, sa, h;
    logic [4:0] x;
    logic       vis, ex, fp;
    logic [1:0] lv;
    logic       go;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input string nm,
                              input logic en, l, r, f, sa, h,
                              input logic [4:0] x,
                              input logic vis, ex, fp,
                              input logic [1:0] lv,
                              input logic go);
    vec_t v;
    v.nm = nm; v.en = en; v.l = l; v.r = r;
    v.f = f; v.sa = sa; v.h = h; v.x = x;
    v.vis = vis; v.ex = ex; v.fp = fp;
    v.lv = lv; v.go = go;
    tv.push_back(v);
  endfunction

  // One clock with the given inputs; outputs sampled 1ns after the edge.
  task automatic cyc(input logic rs, en, l, r, f, sa, h);
    reset = rs; enable = en;
    left_debounced = l; right_debounced = r;
    fire_debounced = f; shot_active = sa; hit = h;
    @(posedge clk_36MHz);
    #1;
  endtask

  task automatic one(input string nm, input string fld,
                     input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%0d expected=%0d", nm, fld, got, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [4:0] x,
                     input logic vis, ex, fp,
                     input logic [1:0] lv, input logic go);
    one(nm, "ship_x", 8'(ship_x), 8'(x));
    one(nm, "ship_visible", 8'(ship_visible), 8'(vis));
    one(nm, "exploding", 8'(exploding), 8'(ex));
    one(nm, "fire_pulse", 8'(fire_pulse), 8'(fp));
    one(nm, "lives", 8'(lives), 8'(lv));
    one(nm, "game_over", 8'(game_over), 8'(go));
  endtask

  task automatic idle_ticks(input int n, input logic l, r, h);
    for (int i = 0; i < n; i++) cyc(0, 1, l, r, 0, 0, h);
  endtask

  initial begin
    //   name         en l r f sa h   x vis ex fp lv go
    add("idle_hit",   0,0,0,0,0,1,    5, 1, 0, 0, 3, 0);
    add("idle_fire",  0,0,0,1,0,0,    5, 1, 0, 0, 3, 0);
    add("idle_frel",  0,0,0,0,0,0,    5, 1, 0, 0, 3, 0);
    add("enter",      1,0,0,0,0,0,    5, 1, 0, 0, 3, 0);
    add("r_t1",       1,0,1,0,0,0,    6, 1, 0, 0, 3, 0);
    add("r_noen",     0,0,1,0,0,0,    6, 1, 0, 0, 3, 0);
    add("r_t2",       1,0,1,0,0,0,    6, 1, 0, 0, 3, 0);
    add("r_t3",       1,0,1,0,0,0,    7, 1, 0, 0, 3, 0);
    add("r_t4",       1,0,1,0,0,0,    7, 1, 0, 0, 3, 0);
    add("r_t5",       1,0,1,0,0,0,    8, 1, 0, 0, 3, 0);
    add("r_t6",       1,0,1,0,0,0,    8, 1, 0, 0, 3, 0);
    add("rel",        1,0,0,0,0,0,    8, 1, 0, 0, 3, 0);
    add("left_now",   1,1,0,0,0,0,    7, 1, 0, 0, 3, 0);
    add("rel2",       1,0,0,0,0,0,    7, 1, 0, 0, 3, 0);
    add("right_now",  1,0,1,0,0,0,    8, 1, 0, 0, 3, 0);
    add("both",       1,1,1,0,0,0,    8, 1, 0, 0, 3, 0);
    add("right_clr",  1,0,1,0,0,0,    9, 1, 0, 0, 3, 0);
    add("rel3",       1,0,0,0,0,0,    9, 1, 0, 0, 3, 0);
    add("fire1",      0,0,0,1,0,0,    9, 1, 0, 1, 3, 0);
    add("fire_hold",  0,0,0,1,0,0,    9, 1, 0, 0, 3, 0);
    add("fire_hold2", 0,0,0,1,0,0,    9, 1, 0, 0, 3, 0);
    add("fire_rel",   0,0,0,0,0,0,    9, 1, 0, 0, 3, 0);
    add("fire_blk",   0,0,0,1,1,0,    9, 1, 0, 0, 3, 0);
    add("fire_unblk", 0,0,0,1,0,0,    9, 1, 0, 0, 3, 0);
    add("fire_rel2",  0,0,0,0,0,0,    9, 1, 0, 0, 3, 0);
    add("fire2",      0,0,0,1,0,0,    9, 1, 0, 1, 3, 0);
    add("fire_rel3",  0,0,0,0,0,0,    9, 1, 0, 0, 3, 0);

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset", 5, 1, 0, 0, 3, 0);

    foreach (tv[i]) begin
      cyc(0, tv[i].en, tv[i].l, tv[i].r, tv[i].f, tv[i].sa, tv[i].h);
      chk(tv[i].nm, tv[i].x, tv[i].vis, tv[i].ex, tv[i].fp,
          tv[i].lv, tv[i].go);
    end

    // 9 steps left need 17 ticks; the rest push against column 0.
    idle_ticks(17, 1, 0, 0);
    chk("left_to_0", 0, 1, 0, 0, 3, 0);
    idle_ticks(4, 1, 0, 0);
    chk("left_sat", 0, 1, 0, 0, 3, 0);
    idle_ticks(1, 0, 0, 0);
    idle_ticks(40, 0, 1, 0);
    chk("right_sat", 19, 1, 0, 0, 3, 0);
    idle_ticks(1, 0, 0, 0);
    idle_ticks(13, 1, 0, 0);
    chk("left_to_12", 12, 1, 0, 0, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    cyc(0, 0, 0, 0, 1, 0, 1);
    chk("hit_fire", 12, 0, 1, 0, 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("hit_again", 12, 0, 1, 0, 2, 0);
    for (int i = 0; i < 29; i++) cyc(0, 1, 1, 0, 1, 0, 1);
    chk("explode_29", 12, 0, 1, 0, 2, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("respawn1", 5, 1, 0, 0, 2, 0);

    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("hit2", 5, 0, 1, 0, 1, 0);
    idle_ticks(30, 0, 0, 0);
    chk("respawn2", 5, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("hit3", 5, 0, 1, 0, 0, 0);
    idle_ticks(30, 0, 0, 0);
    chk("game_over", 5, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, i[0], 0, 1);
    chk("go_absorb", 5, 0, 0, 0, 0, 1);

    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("go_reset", 5, 1, 0, 0, 3, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("hit_b", 5, 0, 1, 0, 2, 0);
    idle_ticks(3, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_mid_exp", 5, 1, 0, 0, 3, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    chk("after_reset_move", 6, 1, 0, 0, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ship_ctrl_param.md
Name: ship_ctrl_param

Overview:
Parametrised player-cannon controller for the Space Invaders core.
- Holds the ship column and moves it on frame ticks with a configurable auto-repeat rate.
- Generates one-shot fire requests.
- Handles hits with an explosion phase, a life counter and game-over.
- Sits between the debounced button inputs and the sprite renderer / shot controller.

Parameters:
X_W, 5, width of ship_x.
X_MAX, 19, rightmost legal column; leftmost is 0.
X_START, 5, column loaded on reset and on respawn.
MOVE_DIV, 2, enable ticks per movement step while a direction is held (>=1).
EXPLODE_TICKS, 30, enable ticks spent in EXPLODING (>=1).
LIVES, 3, initial life count.
LIVES_W, 2, width of lives.

Ports:
clk_36MHz  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  frame tick, one-cycle pulse
left_debounced  in  1  move-left request
right_debounced  in  1  move-right request
fire_debounced  in  1  fire button
shot_active  in  1  player shot in flight; blocks fire
hit  in  1  ship struck (level or pulse)
ship_x  out  X_W  current column
ship_visible  out  1  draw ship sprite
exploding  out  1  draw explosion sprite
fire_pulse  out  1  one-cycle shot launch request
lives  out  LIVES_W  remaining lives
game_over  out  1  no lives left

Behaviour:
- Reset and clocking
  - All state is registered on clk_36MHz; reset has priority over everything.
  - Reset values: state IDLE, ship_x=X_START, lives=LIVES, ship_visible=1, exploding=0, fire_pulse=0, game_over=0, step divider=0, explode counter=0, fire_prev=0.
- States
  - IDLE: ship shown at X_START; hit and fire are ignored. Goes to MOVING on the first enable.
  - MOVING: ship_visible=1.
  - EXPLODING: ship_visible=0, exploding=1.
  - GAME_OVER: ship_visible=0, exploding=0, game_over=1. Absorbing; left only by reset.
- Movement (MOVING only, evaluated on enable cycles)
  - "Held" means exactly one of left_debounced/right_debounced is 1. Both or neither = no move, and the divider clears to 0.
  - While held, on each enable: if divider==0, step ship_x by ±1; then divider = (divider+1) mod MOVE_DIV. The first tick of a press therefore always moves; afterwards the ship moves every MOVE_DIV ticks.
  - Saturation: left at 0 and right at X_MAX leave ship_x unchanged; the divider still advances. No wrap-around.
  - Outside MOVING, the divider is held at 0.
- Fire
  - fire_prev <= fire_debounced every cycle, in every state.
  - fire_pulse=1 in cycle N+1 iff, in cycle N: state==MOVING, fire_debounced=1, fire_prev=0, shot_active=0, hit=0. Otherwise fire_pulse=0.
  - A held button never re-fires; the edge is consumed even when blocked by shot_active.
- Hit
  - In MOVING, hit=1 in any cycle → EXPLODING next cycle. Same edge: lives decrements (saturating at 0) and the explode counter loads EXPLODE_TICKS.
  - Hit beats movement and fire in the same cycle.
  - hit is ignored in IDLE, EXPLODING and GAME_OVER. No double decrement.
- Explosion
  - The counter decrements on each enable in EXPLODING.
  - When an enable finds the counter==1: if lives==0 → GAME_OVER; else → MOVING with ship_x=X_START and divider=0.
- Widths
  - Step arithmetic uses X_W bits with explicit bound compares; no overflow is possible because of saturation.
  - Require X_MAX < 2**X_W, X_START <= X_MAX and LIVES < 2**LIVES_W. Elaboration-time assertion if violated.

Decomposition:
- Package ship_pkg: state encoding localparams (IDLE, MOVING, EXPLODING, GAME_OVER) as 2-bit one-hot-free codes, plus a shared sprite-column width constant.
- One natural sub-module, tick_divider: enable-gated modulo-N counter with synchronous clear and "zero" flag. Instantiated for the step divider; the explode counter stays inline.

Test Plan:
1. Reset, then one enable → state MOVING, ship_x=5, lives=3, ship_visible=1, all other outputs 0.
2. Hold right for 6 enables with MOVE_DIV=2 → ship_x steps on ticks 1, 3, 5, giving 8. Release, then press left → immediate step to 7.
3. Hold left from ship_x=1 for 4 enables, MOVE_DIV=1 → ship_x 0,0,0,0. From X_MAX=19 with right held → stays 19. Both buttons held → no change.
4. Raise fire_debounced with shot_active=0 → fire_pulse high exactly 1 cycle. Keep it held → no second pulse. Release, re-press with shot_active=1 → no pulse. Then shot_active=0 while still held → still no pulse.
5. Hit in MOVING with ship_x=12 → next cycle exploding=1, ship_visible=0, lives=2. Hit again during explosion → lives stays 2. After 30 enables → MOVING, ship_x=5. Hit coinciding with a fire edge → no fire_pulse.
6. Three hits, each followed by 30 enables → final state game_over=1, lives=0, ship_visible=0; buttons and hit ignored. Reset mid-EXPLODING → full reset values next cycle.
